unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares one single-port, fixed-latency unified memory between the IF-stage fetch
//  port and the MEM-stage load/store port of the 5-stage pipelined CPU. Arbitrates,
//  sequences each access (issue, wait, respond), and returns read data with a one-cycle ack.
//  Drives per-port stall signals that the pipeline uses to freeze PC/IF_ID (fetch) or the whole pipe (data).
// PARAMETERS
//  ADDR_W        32  address width
//  DATA_W        32  data width
//  MEM_LATENCY   4   cycles from mem_req to valid mem_rdata (>=1)
//  STARVE_LIMIT  3   max consecutive data grants while if_req pending before fetch is forced (>=1)
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  if_req     in   1       fetch request; held with if_addr until if_ack
//  if_addr    in   ADDR_W  fetch address
//  if_cancel  in   1       discard in-flight fetch (pipeline redirect)
//  if_ack     out  1       one-cycle pulse, if_rdata valid
//  if_rdata   out  DATA_W  fetched instruction
//  if_stall   out  1       if_req & ~if_ack (combinational)
//  d_req      in   1       data request; held with d_we/d_addr/d_wdata until d_ack
//  d_we       in   1       1=store, 0=load
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_ack      out  1       one-cycle pulse, access complete (d_rdata valid for loads)
//  d_rdata    out  DATA_W  load data
//  d_stall    out  1       d_req & ~d_ack (combinational)
//  mem_req    out  1       one-cycle access strobe to memory
//  mem_we     out  1       write enable, valid with mem_req
//  mem_addr   out  ADDR_W  address, valid with mem_req
//  mem_wdata  out  DATA_W  write data, valid with mem_req
//  mem_rdata  in   DATA_W  valid exactly MEM_LATENCY cycles after the mem_req cycle
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  - Reset (async): state=IDLE; all outputs, latched addr/wdata/we, if_rdata, d_rdata,
//    wait counter, starve counter = 0. In-flight access abandoned; its response ignored.
//  - FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//    IDLE: at clock edge with d_req|if_req, pick owner, latch addr/we/wdata, go ISSUE.
//    ISSUE: mem_req=1 (registered, exactly one cycle), cnt<=MEM_LATENCY-1, go WAIT.
//    WAIT: cnt decrements; when cnt==0, capture mem_rdata at edge, go RESP.
//    RESP: owner's ack=1 for one cycle; go IDLE unconditionally (no request sampled in RESP).
//  - Latency: request seen at edge E -> ack high in cycle E+MEM_LATENCY+2. One access per MEM_LATENCY+3 cycles max.
//  - Arbitration in IDLE: data wins, except fetch wins if starve_cnt==STARVE_LIMIT and if_req=1.
//    starve_cnt: +1 on data grant while if_req=1 (saturating at STARVE_LIMIT); cleared on fetch grant
//    or on data grant with if_req=0.
//  - Inputs latched at grant; later changes to addr/wdata/we ignored until the next grant.
//  - Store: mem_we=1; d_ack pulses at normal time; d_rdata unchanged.
//  - Load: d_rdata updated only on load completion; holds value otherwise. if_rdata likewise.
//  - if_cancel: sampled any cycle in ISSUE/WAIT/RESP with owner=fetch -> set cancel flag;
//    memory access still runs to completion, if_ack and if_rdata update suppressed; flag cleared in IDLE.
//    if_cancel in IDLE or with owner=data: no effect.
//  - Requester dropping req mid-transaction: access still completes; ack still pulses.
//  - mem_req never asserted outside ISSUE; at most one outstanding memory access.
//  - if_ack and d_ack never high in the same cycle.
// TESTING
//  1 Single load, L=4: d_req addr 0x10, mem returns 0xDEADBEEF -> mem_req 1 cycle, d_ack at E+6, d_rdata=0xDEADBEEF.
//  2 Simultaneous if_req 0x0 and d_req 0x20 -> data served first, then fetch; if_stall high throughout until if_ack.
//  3 Starvation, STARVE_LIMIT=3: d_req held continuously with if_req -> 3 data grants, 4th grant is fetch, then data resumes.
//  4 Store d_we=1 addr 0x40 data 0x12345678 -> mem_we=1, mem_wdata=0x12345678 in ISSUE, d_ack pulses, d_rdata unchanged.
//  5 if_cancel during WAIT of fetch 0x8 -> no if_ack, if_rdata unchanged, FSM returns IDLE, next request served normally.
//  6 reset asserted mid-WAIT -> outputs 0 immediately (async), busy=0; late mem_rdata ignored; post-reset access correct.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_arbiter
// Description : Shares one single-port, fixed-latency memory between the fetch
//               port and the load/store port, with starvation-bounded priority.
// Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    // fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_cancel,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    // memory port
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] c_cnt_init   = CNT_W'(MEM_LATENCY - 1);
    localparam logic [STV_W-1:0] c_starve_max = STV_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state_q,       state_d;
    logic               owner_fetch_q, owner_fetch_d;
    logic               we_q,          we_d;
    logic [ADDR_W-1:0]  addr_q,        addr_d;
    logic [DATA_W-1:0]  wdata_q,       wdata_d;
    logic [CNT_W-1:0]   cnt_q,         cnt_d;
    logic [STV_W-1:0]   starve_q,      starve_d;
    logic               cancel_q,      cancel_d;
    logic               mem_req_q,     mem_req_d;
    logic               if_ack_q,      if_ack_d;
    logic               d_ack_q,       d_ack_d;
    logic [DATA_W-1:0]  if_rdata_q,    if_rdata_d;
    logic [DATA_W-1:0]  d_rdata_q,     d_rdata_d;

    logic               w_grant_fetch;
    logic               w_cancel_hit;

    // Data normally wins; fetch is forced once data has been granted
    // STARVE_LIMIT times in a row while fetch was waiting.
    assign w_grant_fetch = if_req && (!d_req || (starve_q == c_starve_max));
    assign w_cancel_hit  = (state_q != S_IDLE) && owner_fetch_q && if_cancel;

    always_comb begin
        state_d       = state_q;
        owner_fetch_d = owner_fetch_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        cnt_d         = cnt_q;
        starve_d      = starve_q;
        cancel_d      = cancel_q;
        mem_req_d     = 1'b0;
        if_ack_d      = 1'b0;
        d_ack_d       = 1'b0;
        if_rdata_d    = if_rdata_q;
        d_rdata_d     = d_rdata_q;

        if (w_cancel_hit) begin
            cancel_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                cancel_d = 1'b0;
                if (d_req || if_req) begin
                    state_d       = S_ISSUE;
                    mem_req_d     = 1'b1;
                    owner_fetch_d = w_grant_fetch;
                    if (w_grant_fetch) begin
                        addr_d   = if_addr;
                        we_d     = 1'b0;
                        wdata_d  = '0;
                        starve_d = '0;
                    end else begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                        if (!if_req) begin
                            starve_d = '0;
                        end else if (starve_q != c_starve_max) begin
                            starve_d = starve_q + STV_W'(1);
                        end
                    end
                end
            end

            S_ISSUE: begin
                cnt_d   = c_cnt_init;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    // A cancel seen on the capture cycle itself still suppresses the ack.
                    if (owner_fetch_q) begin
                        if (!(cancel_q || w_cancel_hit)) begin
                            if_ack_d   = 1'b1;
                            if_rdata_d = mem_rdata;
                        end
                    end else begin
                        d_ack_d = 1'b1;
                        if (!we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            owner_fetch_q <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            cnt_q         <= '0;
            starve_q      <= '0;
            cancel_q      <= 1'b0;
            mem_req_q     <= 1'b0;
            if_ack_q      <= 1'b0;
            d_ack_q       <= 1'b0;
            if_rdata_q    <= '0;
            d_rdata_q     <= '0;
        end else begin
            state_q       <= state_d;
            owner_fetch_q <= owner_fetch_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            cnt_q         <= cnt_d;
            starve_q      <= starve_d;
            cancel_q      <= cancel_d;
            mem_req_q     <= mem_req_d;
            if_ack_q      <= if_ack_d;
            d_ack_q       <= d_ack_d;
            if_rdata_q    <= if_rdata_d;
            d_rdata_q     <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_req_q && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign if_stall  = if_req && !if_ack_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_stall   = d_req && !d_ack_q;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_unified_mem_arbiter
// Description : Directed self-checking bench for unified_mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int MEM_LATENCY  = 4;
    localparam int STARVE_LIMIT = 3;

    logic              clk;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_cancel;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    int tests_run    = 0;
    int tests_failed = 0;

    unified_mem_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .MEM_LATENCY (MEM_LATENCY),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_cancel(if_cancel),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .if_stall (if_stall),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .d_stall  (d_stall),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: fixed contents plus one write overlay; data is driven
    // only during the single cycle MEM_LATENCY cycles after the request.
    logic                   mem_clr;
    logic [MEM_LATENCY-1:0] vld;
    logic [ADDR_W-1:0]      vaddr [MEM_LATENCY];
    logic                   wr_valid;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;

    function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
        if (wr_valid && wr_addr == a) return wr_data;
        case (a)
            32'h0000_0000: return 32'h0000_0013;
            32'h0000_0010: return 32'hDEAD_BEEF;
            32'h0000_0020: return 32'hCAFE_0020;
            default:       return 32'h0A00_0000 | a;
        endcase
    endfunction

    always @(posedge clk or posedge mem_clr) begin
        if (mem_clr) begin
            vld      <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) vaddr[i] <= '0;
        end else begin
            if (mem_req && mem_we) begin
                wr_valid <= 1'b1;
                wr_addr  <= mem_addr;
                wr_data  <= mem_wdata;
            end
            vld      <= {vld[MEM_LATENCY-2:0], mem_req};
            vaddr[0] <= mem_addr;
            for (int i = 1; i < MEM_LATENCY; i++) vaddr[i] <= vaddr[i-1];
        end
    end

    assign mem_rdata = vld[MEM_LATENCY-1] ? mem_val(vaddr[MEM_LATENCY-1]) : 32'hBAD0_BAD0;

    task automatic test_reset();
        reset = 1'b1;
        #1;
        tests_run++;
        if ({busy, if_ack, d_ack, mem_req, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: busy=%b mem_req=%b if_rdata=%h d_rdata=%h expected all 0",
                     busy, mem_req, if_rdata, d_rdata);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || d_stall !== 1'b0 || if_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: busy=%b d_stall=%b if_stall=%b expected 0", busy, d_stall, if_stall);
        end
    endtask

    task automatic test_single_load();
        int ack_at = 0, req_at = 0, req_cnt = 0, stall_bad = 0;
        d_we = 1'b0; d_addr = 32'h10; d_wdata = '0; d_req = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (mem_req) begin req_cnt++; req_at = n; end
            if (d_ack && ack_at == 0) begin
                ack_at = n;
                d_req  = 1'b0;
            end else if (ack_at == 0 && d_stall !== 1'b1) begin
                stall_bad++;
            end
            if (n == 1) d_addr = 32'h50;
        end
        tests_run++;
        if (ack_at != 6) begin tests_failed++; $display("FAIL load_ack_time: got %0d expected 6", ack_at); end
        tests_run++;
        if (req_cnt != 1) begin tests_failed++; $display("FAIL load_mem_req_count: got %0d expected 1", req_cnt); end
        tests_run++;
        if (req_at != 1) begin tests_failed++; $display("FAIL load_mem_req_time: got %0d expected 1", req_at); end
        tests_run++;
        if (d_rdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL load_rdata: got %h expected deadbeef", d_rdata); end
        tests_run++;
        if (stall_bad != 0) begin tests_failed++; $display("FAIL load_d_stall: %0d low cycles expected 0", stall_bad); end
    endtask

    task automatic test_simultaneous();
        int d_at = 0, i_at = 0, both = 0, stall_bad = 0;
        if_addr = 32'h0; if_req = 1'b1;
        d_we = 1'b0; d_addr = 32'h20; d_req = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (d_ack && if_ack) both++;
            if (i_at == 0 && !if_ack && if_stall !== 1'b1) stall_bad++;
            if (d_ack && d_at == 0) begin d_at = n; d_req = 1'b0; end
            if (if_ack && i_at == 0) begin i_at = n; if_req = 1'b0; end
        end
        tests_run++;
        if (d_at != 6) begin tests_failed++; $display("FAIL simul_d_ack_time: got %0d expected 6", d_at); end
        tests_run++;
        if (i_at != 13) begin tests_failed++; $display("FAIL simul_if_ack_time: got %0d expected 13", i_at); end
        tests_run++;
        if (both != 0) begin tests_failed++; $display("FAIL simul_both_acks: got %0d expected 0", both); end
        tests_run++;
        if (stall_bad != 0) begin tests_failed++; $display("FAIL simul_if_stall: %0d low cycles expected 0", stall_bad); end
        tests_run++;
        if (if_rdata !== 32'h0000_0013) begin tests_failed++; $display("FAIL simul_if_rdata: got %h expected 00000013", if_rdata); end
        tests_run++;
        if (d_rdata !== 32'hCAFE_0020) begin tests_failed++; $display("FAIL simul_d_rdata: got %h expected cafe0020", d_rdata); end
    endtask

    task automatic test_starvation();
        logic [4:0] order = '0;
        int acks = 0, both = 0;
        if_addr = 32'h4; if_req = 1'b1;
        d_we = 1'b0; d_addr = 32'h30; d_req = 1'b1;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (d_ack && if_ack) both++;
            if ((d_ack || if_ack) && acks < 5) begin
                order[acks] = if_ack;
                acks++;
                if (acks == 5) begin d_req = 1'b0; if_req = 1'b0; end
            end
        end
        tests_run++;
        if (acks != 5 || order !== 5'b01000 || both != 0) begin
            tests_failed++;
            $display("FAIL starve_order: acks=%0d order=%b both=%0d expected 5 01000 0", acks, order, both);
        end
        tests_run++;
        if (if_rdata !== 32'h0A00_0004) begin tests_failed++; $display("FAIL starve_if_rdata: got %h expected 0a000004", if_rdata); end
        tests_run++;
        if (d_rdata !== 32'h0A00_0030) begin tests_failed++; $display("FAIL starve_d_rdata: got %h expected 0a000030", d_rdata); end
    endtask

    task automatic test_store();
        int ack_at = 0;
        logic issue_ok = 1'b0;
        d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234_5678; d_req = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1 && mem_req === 1'b1 && mem_we === 1'b1 &&
                mem_wdata === 32'h1234_5678 && mem_addr === 32'h40) issue_ok = 1'b1;
            if (n == 1) d_wdata = 32'hFFFF_FFFF;
            if (d_ack && ack_at == 0) begin ack_at = n; d_req = 1'b0; d_we = 1'b0; end
        end
        tests_run++;
        if (!issue_ok) begin tests_failed++; $display("FAIL store_issue: issue_ok=%b expected 1", issue_ok); end
        tests_run++;
        if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL store_we_idle: got %b expected 0", mem_we); end
        tests_run++;
        if (ack_at != 6) begin tests_failed++; $display("FAIL store_ack_time: got %0d expected 6", ack_at); end
        tests_run++;
        if (d_rdata !== 32'h0A00_0030) begin tests_failed++; $display("FAIL store_d_rdata: got %h expected 0a000030", d_rdata); end
    endtask

    task automatic test_cancel();
        int if_acks = 0, busy_at8 = -1, ack_at = 0;
        if_addr = 32'h8; if_req = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (if_ack) if_acks++;
            if (n == 8) busy_at8 = int'(busy);
            if (n == 3) begin if_cancel = 1'b1; if_req = 1'b0; end
            if (n == 4) if_cancel = 1'b0;
        end
        tests_run++;
        if (if_acks != 0) begin tests_failed++; $display("FAIL cancel_if_ack: got %0d acks expected 0", if_acks); end
        tests_run++;
        if (if_rdata !== 32'h0A00_0004) begin tests_failed++; $display("FAIL cancel_if_rdata: got %h expected 0a000004", if_rdata); end
        tests_run++;
        if (busy_at8 != 0) begin tests_failed++; $display("FAIL cancel_busy: got %0d expected 0", busy_at8); end
        d_we = 1'b0; d_addr = 32'h40; d_req = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (d_ack && ack_at == 0) begin ack_at = n; d_req = 1'b0; end
        end
        tests_run++;
        if (ack_at != 6 || d_rdata !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL cancel_next_load: ack_at=%0d d_rdata=%h expected 6 12345678", ack_at, d_rdata);
        end
    endtask

    task automatic test_reset_mid_wait();
        int late_acks = 0, rdata_bad = 0, ack_at = 0;
        d_we = 1'b0; d_addr = 32'h10; d_req = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        d_req = 1'b0;
        #1;
        tests_run++;
        if ({busy, d_ack, mem_req, d_rdata, if_rdata, mem_addr} !== '0) begin
            tests_failed++;
            $display("FAIL rst_async: busy=%b d_rdata=%h if_rdata=%h mem_addr=%h expected 0",
                     busy, d_rdata, if_rdata, mem_addr);
        end
        #2;
        reset = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (d_ack || if_ack || busy) late_acks++;
            if (d_rdata !== '0) rdata_bad++;
        end
        tests_run++;
        if (late_acks != 0 || rdata_bad != 0) begin
            tests_failed++;
            $display("FAIL rst_late_data: activity=%0d rdata_changes=%0d expected 0 0", late_acks, rdata_bad);
        end
        d_addr = 32'h10; d_req = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (d_ack && ack_at == 0) begin ack_at = n; d_req = 1'b0; end
        end
        tests_run++;
        if (ack_at != 6) begin tests_failed++; $display("FAIL rst_post_ack_time: got %0d expected 6", ack_at); end
        tests_run++;
        if (d_rdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL rst_post_rdata: got %h expected deadbeef", d_rdata); end
    endtask

    initial begin
        mem_clr   = 1'b1;
        reset     = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        if_cancel = 1'b0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        #1 mem_clr = 1'b0;
        test_reset();
        test_single_load();
        test_simultaneous();
        test_starvation();
        test_store();
        test_cancel();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
